// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-level round-robin arbiter sharing one uart_tx_ctrl byte port.
// A requester keeps the grant from its first byte to its req_last byte; a watchdog
// revokes a grant that stalls for IDLE_TIMEOUT cycles.
// Optional feature macro: UART_ARB_HDR_EN (emit header byte {5'b10100, grant_id} per grant).
module uart_tx_arbiter #(
  parameter int unsigned CH_NUM       = 4,
  parameter logic [15:0] IDLE_TIMEOUT = 16'd50000,
  parameter int unsigned U_DLY        = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [8*CH_NUM-1:0]   req_data,
  input  logic [CH_NUM-1:0]     req_valid,
  input  logic [CH_NUM-1:0]     req_last,
  output logic [CH_NUM-1:0]     req_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  arb_timeout
);

  // Non-blocking assignments are zero-delay; U_DLY only appears in the config report.
  if (CH_NUM < 2 || CH_NUM > 8 || IDLE_TIMEOUT == 16'd0) begin : g_bad_cfg
    $error("uart_tx_arbiter: bad config CH_NUM=%0d IDLE_TIMEOUT=%0d U_DLY=%0d",
           CH_NUM, IDLE_TIMEOUT, U_DLY);
  end

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
`ifdef UART_ARB_HDR_EN
    ArbHdr  = 2'd1,
`endif
    ArbData = 2'd2
  } arb_state_e;

  arb_state_e  r_state;
  logic [2:0]  r_grant_id;
  logic [2:0]  r_rr_ptr;
  logic [15:0] r_idle_cnt;
  logic        r_busy;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_arb_timeout;

  logic        w_sel_found;
  logic [2:0]  w_sel_id;
  logic [7:0]  w_gnt_data;
  logic        w_gnt_valid;
  logic        w_gnt_last;
  logic        w_xfer;
  logic [2:0]  w_next_ptr;

  // Round-robin pick: first requester at or above rr_ptr, else wrap to the lowest one.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = 3'd0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (!w_sel_found && req_valid[i] && (3'(i) >= r_rr_ptr)) begin
        w_sel_found = 1'b1;
        w_sel_id    = 3'(i);
      end
    end
    for (int i = 0; i < CH_NUM; i++) begin
      if (!w_sel_found && req_valid[i]) begin
        w_sel_found = 1'b1;
        w_sel_id    = 3'(i);
      end
    end
  end

  // Mux the granted channel's byte, valid and last flag.
  always_comb begin
    w_gnt_data  = 8'h00;
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_gnt_data  = req_data[8*i +: 8];
        w_gnt_valid = req_valid[i];
        w_gnt_last  = req_last[i];
      end
    end
  end

  // Ready goes only to the owner and only from state + tx_ready, never from req_valid.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      req_ready[i] = (r_state == ArbData) && (r_grant_id == 3'(i)) && tx_ready;
    end
  end

  assign w_xfer     = (r_state == ArbData) && w_gnt_valid && tx_ready;
  assign w_next_ptr = (r_grant_id == 3'(CH_NUM - 1)) ? 3'd0 : r_grant_id + 3'd1;

  // Arbitration FSM with watchdog and registered strobe/data outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ArbIdle;
      r_grant_id    <= 3'd0;
      r_rr_ptr      <= 3'd0;
      r_idle_cnt    <= 16'd0;
      r_busy        <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_arb_timeout <= 1'b0;
    end else begin
      r_tx_valid    <= 1'b0;
      r_arb_timeout <= 1'b0;
      unique case (r_state)
        ArbIdle: begin
          if (w_sel_found) begin
            r_grant_id <= w_sel_id;
            r_busy     <= 1'b1;
            r_idle_cnt <= 16'd0;
`ifdef UART_ARB_HDR_EN
            r_state    <= ArbHdr;
`else
            r_state    <= ArbData;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        ArbHdr: begin
          // Header is not watchdog-guarded; it waits only on tx_ready.
          if (tx_ready) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= {5'b10100, r_grant_id};
            r_idle_cnt <= 16'd0;
            r_state    <= ArbData;
          end
        end
`endif
        ArbData: begin
          if (w_xfer) begin
            // A transfer beats a coincident timeout.
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_gnt_data;
            r_idle_cnt <= 16'd0;
            if (w_gnt_last) begin
              r_rr_ptr <= w_next_ptr;
              r_busy   <= 1'b0;
              r_state  <= ArbIdle;
            end
          end else if (r_idle_cnt == IDLE_TIMEOUT - 16'd1) begin
            r_arb_timeout <= 1'b1;
            r_rr_ptr      <= w_next_ptr;
            r_busy        <= 1'b0;
            r_idle_cnt    <= 16'd0;
            r_state       <= ArbIdle;
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end
        end
        default: r_state <= ArbIdle;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign arb_timeout = r_arb_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes (channel, data) are queued when a
// frame is scheduled and checked on each tx_valid strobe.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

`ifdef UART_ARB_HDR_EN
  localparam int unsigned CH  = 8;
  localparam int          Hdr = 1;
`else
  localparam int unsigned CH  = 4;
  localparam int          Hdr = 0;
`endif
  localparam logic [15:0] Tmo = 16'd16;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [8*CH-1:0] req_data  = '0;
  logic [CH-1:0]   req_valid = '0;
  logic [CH-1:0]   req_last  = '0;
  logic [CH-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready  = 1'b1;
  logic [2:0]      grant_id;
  logic            busy;
  logic            arb_timeout;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [10:0] sb[$];
  logic [10:0] sb_exp;
  int          strobes[$];

  uart_tx_arbiter #(
    .CH_NUM      (CH),
    .IDLE_TIMEOUT(Tmo),
    .U_DLY       (1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .arb_timeout(arb_timeout)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe monitor: pop expected byte and owner on each tx_valid.
  always @(negedge sys_clk) begin
    if (sys_rst_n && tx_valid) begin
      strobes.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_tx_valid", 32'(tx_valid), 32'd0);
      end else begin
        sb_exp = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(sb_exp[7:0]));
        check("strobe_grant_id", 32'(grant_id), 32'(sb_exp[10:8]));
      end
    end
  end

  task automatic expect_frame(input int ch, input logic [63:0] bytes, input int n);
    if (Hdr != 0) sb.push_back({3'(ch), 5'b10100, 3'(ch)});
    for (int i = 0; i < n; i++) sb.push_back({3'(ch), bytes[8*i +: 8]});
  endtask

  task automatic send_frame(input int ch, input logic [63:0] bytes, input int n,
                            input bit with_last);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      req_data[8*ch +: 8] = bytes[8*i +: 8];
      req_last[ch]        = with_last && (i == n - 1);
      req_valid[ch]       = 1'b1;
      @(negedge sys_clk);
      while (!req_ready[ch] && g < 300) begin
        g++;
        @(negedge sys_clk);
      end
      check("accept_wait", 32'(req_ready[ch]), 32'd1);
      @(posedge sys_clk);
      #1;
    end
    req_valid[ch] = 1'b0;
    req_last[ch]  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge sys_clk);
      g++;
    end
    repeat (2) @(negedge sys_clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_arb_timeout"}, 32'(arb_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Contention: ch0, ch2, ch3 together right after reset -> order 0, 2, 3.
    @(posedge sys_clk);
    #1;
    strobes.delete();
    expect_frame(0, 64'h0201, 2);
    expect_frame(2, 64'h2221, 2);
    expect_frame(3, 64'h3231, 2);
    fork
      send_frame(0, 64'h0201, 2, 1'b1);
      send_frame(2, 64'h2221, 2, 1'b1);
      send_frame(3, 64'h3231, 2, 1'b1);
    join
    wait_drain();
    check("contention_strobes", 32'(strobes.size()), 32'(3 * (2 + Hdr)));
    for (int i = 1; i < strobes.size(); i++)
      check("contention_gap", 32'(strobes[i] - strobes[i-1]),
            (i % (2 + Hdr) == 0) ? 32'd2 : 32'd1);

    // Single frame on ch1.
    strobes.delete();
    expect_frame(1, 64'h332211, 3);
    send_frame(1, 64'h332211, 3, 1'b1);
    @(negedge sys_clk);
    check("single_busy_after", 32'(busy), 32'd0);
    wait_drain();
    check("single_strobes", 32'(strobes.size()), 32'(3 + Hdr));
    for (int i = 1; i < strobes.size(); i++)
      check("single_gap", 32'(strobes[i] - strobes[i-1]), 32'd1);

    // Back-pressure: tx_ready low for 10 cycles after the first data byte.
    strobes.delete();
    expect_frame(1, 64'h44434241, 4);
    fork
      send_frame(1, 64'h44434241, 4, 1'b1);
      begin
        g = 0;
        @(negedge sys_clk);
        while (!req_ready[1] && g < 50) begin
          g++;
          @(negedge sys_clk);
        end
        @(posedge sys_clk);
        #1 tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge sys_clk);
          check("bp_req_ready", 32'(req_ready), 32'd0);
          if (i > 0) check("bp_tx_valid", 32'(tx_valid), 32'd0);
        end
        @(posedge sys_clk);
        #1 tx_ready = 1'b1;
        @(negedge sys_clk);
        check("bp_tx_valid_tail", 32'(tx_valid), 32'd0);
        check("bp_resume_ready", 32'(req_ready[1]), 32'd1);
      end
    join
    wait_drain();
    check("bp_strobes", 32'(strobes.size()), 32'(4 + Hdr));
    check("bp_gap_stall", 32'(strobes[Hdr+1] - strobes[Hdr]), 32'd11);
    check("bp_gap_b2", 32'(strobes[Hdr+2] - strobes[Hdr+1]), 32'd1);
    check("bp_gap_b3", 32'(strobes[Hdr+3] - strobes[Hdr+2]), 32'd1);

    // Watchdog: ch2 stalls after one byte.
    strobes.delete();
    expect_frame(2, 64'h5A, 1);
    send_frame(2, 64'h5A, 1, 1'b0);
    g = 0;
    @(negedge sys_clk);
    while (!arb_timeout && g < 60) begin
      g++;
      @(negedge sys_clk);
    end
    check("wd_pulse_seen", 32'(arb_timeout), 32'd1);
    check("wd_latency", 32'(cyc - strobes[Hdr]), 32'd16);
    check("wd_busy", 32'(busy), 32'd0);
    @(negedge sys_clk);
    check("wd_pulse_width", 32'(arb_timeout), 32'd0);
    wait_drain();

    // After the timeout rr_ptr is 3: ch3 wins over ch2.
    expect_frame(3, 64'h3C, 1);
    expect_frame(2, 64'h2C, 1);
    fork
      send_frame(3, 64'h3C, 1, 1'b1);
      send_frame(2, 64'h2C, 1, 1'b1);
    join
    wait_drain();

    // Reset during the 2nd byte of a ch0 frame (rr_ptr is 3 beforehand).
    expect_frame(0, 64'hC1, 1);
    @(posedge sys_clk);
    #1;
    req_data[7:0] = 8'hC1;
    req_last[0]   = 1'b0;
    req_valid[0]  = 1'b1;
    g = 0;
    @(negedge sys_clk);
    while (!req_ready[0] && g < 50) begin
      g++;
      @(negedge sys_clk);
    end
    @(posedge sys_clk);
    #1 req_data[7:0] = 8'hC2;
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    req_valid = '0;
    req_last  = '0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("midrst_sb", 32'(sb.size()), 32'd0);
    expect_frame(0, 64'hD0, 1);
    expect_frame(3, 64'hD3, 1);
    fork
      send_frame(3, 64'hD3, 1, 1'b1);
      send_frame(0, 64'hD0, 1, 1'b1);
    join
    wait_drain();

`ifdef UART_ARB_HDR_EN
    // Header mode: ch5 frame yields A5 then 7E on consecutive strobes.
    strobes.delete();
    expect_frame(5, 64'h7E, 1);
    send_frame(5, 64'h7E, 1, 1'b1);
    wait_drain();
    check("hdr_strobes", 32'(strobes.size()), 32'd2);
    check("hdr_gap", 32'(strobes[1] - strobes[0]), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
